time_set_keys: RTL

Input-side counterpart to the clock's display path. It synchronises and debounces three raw push-buttons (mode, up, down) and runs a small edit state machine that lets the user set hours and minutes. It gates the clock's run flag while editing and issues a one-cycle load pulse carrying the new hour/minute into the time counters. It sits between the board key pins and the hour/minute/second counter block.

---
 rtl/time_set_keys_pkg.sv | 9 +
 rtl/time_set_keys_debounce.sv | 35 +++
 rtl/time_set_keys.sv | 89 ++++++++
 3 files changed

// File: rtl/time_set_keys_pkg.sv
// time_set_keys_pkg: edit FSM encoding, field codes and time-of-day limits shared with the counter block.
package time_set_keys_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_EDIT_HOUR, ST_EDIT_MINUTE} state_t;
  localparam logic [1:0] EDIT_NONE   = 2'd0;
  localparam logic [1:0] EDIT_HOUR   = 2'd1;
  localparam logic [1:0] EDIT_MINUTE = 2'd2;
  localparam logic [4:0] HOUR_MAX    = 5'd23;
  localparam logic [5:0] MINUTE_MAX  = 6'd59;
endpackage

// File: rtl/time_set_keys_debounce.sv
// key_debounce: 2-flop synchroniser, stability counter and rising-edge press pulse for one raw key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  // any cycle back at the current level restarts the stability count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;
endmodule

// File: rtl/time_set_keys.sv
// time_set_keys: debounced mode/up/down keys driving an hour/minute edit FSM that gates run and pulses load.
module time_set_keys
  import time_set_keys_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 32768,
  parameter int REPEAT_CYCLES   = 8192
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic       run,
  output logic       load,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [1:0] edit_field
);
  localparam int RW = $clog2(HOLD_CYCLES + 1);
  logic w_mode_level, w_mode_press, w_up_level, w_up_press, w_dn_level, w_dn_press;
  logic w_up_rep, w_dn_rep, w_ev_mode, w_inc, w_dec;
  logic [RW-1:0] r_up_rep, r_dn_rep;
  logic [5:0] w_hour_p1;
  logic [6:0] w_min_p1;
  logic [4:0] w_hour_step, r_hour;
  logic [5:0] w_min_step, r_min;
  logic       r_load;
  state_t     r_state, w_next;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .i_key(key_mode), .o_level(w_mode_level), .o_press(w_mode_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clock(clock), .reset(reset), .i_key(key_up), .o_level(w_up_level), .o_press(w_up_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clock(clock), .reset(reset), .i_key(key_down), .o_level(w_dn_level), .o_press(w_dn_press));

  // repeat counter sits at 0 on the press cycle; after each repeat it rewinds so the next fires REPEAT_CYCLES later
  assign w_up_rep  = w_up_level && r_up_rep == RW'(HOLD_CYCLES);
  assign w_dn_rep  = w_dn_level && r_dn_rep == RW'(HOLD_CYCLES);
  assign w_ev_mode = w_mode_press & w_mode_level;
  assign w_inc     = (w_up_press | w_up_rep) & ~(w_dn_press | w_dn_rep);
  assign w_dec     = (w_dn_press | w_dn_rep) & ~(w_up_press | w_up_rep);

  always_comb begin
    w_hour_p1   = {1'b0, r_hour} + 6'd1;
    w_min_p1    = {1'b0, r_min} + 7'd1;
    w_hour_step = w_inc ? (w_hour_p1 > {1'b0, HOUR_MAX} ? 5'd0 : w_hour_p1[4:0])
                : w_dec ? (r_hour == 5'd0 ? HOUR_MAX : r_hour - 5'd1) : r_hour;
    w_min_step  = w_inc ? (w_min_p1 > {1'b0, MINUTE_MAX} ? 6'd0 : w_min_p1[5:0])
                : w_dec ? (r_min == 6'd0 ? MINUTE_MAX : r_min - 6'd1) : r_min;
    w_next      = !w_ev_mode ? r_state
                : r_state == ST_RUN ? ST_EDIT_HOUR
                : r_state == ST_EDIT_HOUR ? ST_EDIT_MINUTE : ST_RUN;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_up_rep <= '0;
      r_dn_rep <= '0;
      r_hour   <= '0;
      r_min    <= '0;
      r_load   <= 1'b0;
    end else begin
      r_up_rep <= !w_up_level ? '0 : w_up_rep ? RW'(HOLD_CYCLES - REPEAT_CYCLES + 1) : r_up_rep + RW'(1);
      r_dn_rep <= !w_dn_level ? '0 : w_dn_rep ? RW'(HOLD_CYCLES - REPEAT_CYCLES + 1) : r_dn_rep + RW'(1);
      r_load   <= w_ev_mode && r_state == ST_EDIT_MINUTE;
      if (r_state == ST_RUN && w_ev_mode) begin
        r_hour <= cur_hour;
        r_min  <= cur_minute;
      end
      if (r_state == ST_EDIT_HOUR) r_hour <= w_hour_step;
      if (r_state == ST_EDIT_MINUTE) r_min <= w_min_step;
    end
  end

  assign run        = r_state == ST_RUN;
  assign load       = r_load;
  assign set_hour   = r_hour;
  assign set_minute = r_min;
  assign edit_field = r_state == ST_EDIT_HOUR ? EDIT_HOUR : r_state == ST_EDIT_MINUTE ? EDIT_MINUTE : EDIT_NONE;
endmodule
